// File: rtl/axil_reg_bank_pkg.sv
// Shared types and helpers for the axil_reg_bank AXI4-Lite register bank.
// Response codes, FSM state enums and the byte-strobe merge function.
package axil_reg_bank_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  // Callers zero-extend narrower buses to the maximum width and truncate the result.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(MAX_STRB_W); b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_bank_decode.sv
// Word-index decoder for axil_reg_bank: classifies an index as RW, RO or out of range.
// Purely combinational; the top instantiates one for the write path and one for the read path.
module axil_reg_bank_decode
  import axil_reg_bank_pkg::*;
#(
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 4,
  parameter int IDX_W  = 6
) (
  input  logic [IDX_W-1:0] idx,
  output logic             is_rw,
  output logic             is_ro,
  output logic [IDX_W-1:0] rw_sel,
  output logic [IDX_W-1:0] ro_sel,
  output logic             err
);

  // Compare in 32-bit so a fully populated index space does not wrap the bounds.
  always_comb begin
    is_rw  = int'(idx) < NUM_RW;
    is_ro  = !is_rw && (int'(idx) < NUM_RW + NUM_RO);
    err    = !is_rw && !is_ro;
    rw_sel = idx;
    ro_sel = idx - IDX_W'(NUM_RW);
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_RW control registers followed by NUM_RO status words.
// Define AXIL_REG_BANK_WPULSE_EN to add wr_pulse_o, a one-clock strobe per committed RW write.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int              DATA_W  = 32,
  parameter int              NUM_RW  = 4,
  parameter int              NUM_RO  = 4,
  parameter int              ADDR_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_RW*DATA_W-1:0]   ctrl_o,
  input  logic [NUM_RO*DATA_W-1:0]   status_i
`ifdef AXIL_REG_BANK_WPULSE_EN
  ,
  output logic [NUM_RW-1:0]          wr_pulse_o
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;

  wr_state_t                        wr_state_q, wr_state_d;
  logic                             aw_held_q, aw_held_d;
  logic                             w_held_q, w_held_d;
  logic [ADDR_W-1:0]                awaddr_q, awaddr_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic [STRB_W-1:0]                wstrb_q, wstrb_d;
  logic                             awready_q, awready_d;
  logic                             wready_q, wready_d;
  logic                             bvalid_q, bvalid_d;
  axil_resp_t                       bresp_q, bresp_d;
  logic [NUM_RW-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [NUM_RW-1:0]                pulse_q, pulse_d;

  rd_state_t                        rd_state_q, rd_state_d;
  logic                             arready_q, arready_d;
  logic                             rvalid_q, rvalid_d;
  logic [DATA_W-1:0]                rdata_q, rdata_d;
  axil_resp_t                       rresp_q, rresp_d;

  logic [NUM_RO-1:0][DATA_W-1:0]    status_w;
  logic [DATA_W-1:0]                rd_val;
  logic                             aw_fire, w_fire, ar_fire, commit;

  logic                             wr_is_rw, wr_is_ro, wr_err;
  logic [IDX_W-1:0]                 wr_rw_sel, wr_ro_sel;
  logic                             rd_is_rw, rd_is_ro, rd_err;
  logic [IDX_W-1:0]                 rd_rw_sel, rd_ro_sel;

  assign status_w = status_i;

  axil_reg_bank_decode #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_wr_decode (
    .idx    (awaddr_q[ADDR_W-1:OFF_W]),
    .is_rw  (wr_is_rw),
    .is_ro  (wr_is_ro),
    .rw_sel (wr_rw_sel),
    .ro_sel (wr_ro_sel),
    .err    (wr_err)
  );

  axil_reg_bank_decode #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_rd_decode (
    .idx    (S_AXI_ARADDR[ADDR_W-1:OFF_W]),
    .is_rw  (rd_is_rw),
    .is_ro  (rd_is_ro),
    .rw_sel (rd_rw_sel),
    .ro_sel (rd_ro_sel),
    .err    (rd_err)
  );

  // Writes to the RO region and beyond are both refused, so only is_rw matters on this path.
  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q[OFF_W-1:0],
                       S_AXI_ARADDR[OFF_W-1:0], wr_is_ro, wr_ro_sel, wr_err};

  // Write channel: AW and W are captured independently, committed together one edge later.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    pulse_d    = '0;

    aw_fire = S_AXI_AWVALID && awready_q;
    w_fire  = S_AXI_WVALID && wready_q;
    commit  = (wr_state_q == WR_IDLE) && aw_held_q && w_held_q;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    case (wr_state_q)
      WR_IDLE: begin
        if (commit) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_is_rw ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
          for (int k = 0; k < NUM_RW; k++) begin
            if (wr_is_rw && (wr_rw_sel == IDX_W'(k))) begin
              regs_d[k]  = DATA_W'(strb_merge(MAX_DATA_W'(regs_q[k]), MAX_DATA_W'(wdata_q),
                                              MAX_STRB_W'(wstrb_q)));
              pulse_d[k] = 1'b1;
            end
          end
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    awready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
  end

  // Read mux sees regs_q, so a read racing a commit to the same word returns the old value.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (rd_is_rw && (rd_rw_sel == IDX_W'(k))) rd_val = regs_q[k];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (rd_is_ro && (rd_ro_sel == IDX_W'(k))) rd_val = status_w[k];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ar_fire    = S_AXI_ARVALID && arready_q;

    case (rd_state_q)
      RD_IDLE: begin
        if (ar_fire) begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          rdata_d    = rd_val;
          rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    arready_d = (rd_state_d == RD_IDLE);
  end

  // NOTE: the control registers are reset because ctrl_o feeds live datapath logic.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      regs_q     <= {NUM_RW{RST_VAL}};
      pulse_q    <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_o        = regs_q;

`ifdef AXIL_REG_BANK_WPULSE_EN
  assign wr_pulse_o = pulse_q;
`else
  logic unused_pulse;
  assign unused_pulse = &{1'b0, pulse_q};
`endif

endmodule
